pipelined_adder_sub: RTL and testbench
======================================

# pipelined_adder_sub

Parametrised, pipelined ripple-carry adder/subtractor and the successor to the 4-bit combinational ripple-carry adder. It generalises operand width and splits the carry chain into registered slices. It adds a subtract mode, a signed-overflow flag and valid/ready flow control on both sides. It sits in the datapath wherever a wide add/sub must close timing at clock rates that a full-width ripple chain cannot meet.

## Interface
- WIDTH, 16: operand and sum width in bits; must be ≥ 2.
- STAGES, 4: number of pipeline slices. Must divide WIDTH. SLICE = WIDTH/STAGES bits per stage.
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- in_valid  input  1  operands on a/b/cin/sub are valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: add, 1: subtract
- out_valid  output  1  result fields are valid
- out_ready  input  1  downstream accepts the result this cycle
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry-out (add) / borrow-out (sub)
- ovf  output  1  two's-complement signed overflow

## Operation
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: sum = (a − b − cin) mod 2^WIDTH, computed as a + ~b + ~cin. cout = NOT(carry out of MSB), i.e. 1 when a < b + cin as unsigned values.
- Signed overflow: ovf = 1 when a[MSB] equals the effective b[MSB] (b[MSB] for add, ~b[MSB] for sub) and sum[MSB] differs from that bit.
- Pipeline structure:
  - Stage k (0..STAGES−1) adds bit slice k using the registered carry from stage k−1. Stage 0 uses the effective carry-in.
  - Upper slices of a and effective b are carried forward (skewed) in registers until their stage.
  - Completed lower sum slices are delayed so that all slices of one transaction exit together.
- Each stage holds a valid bit. The sub and a[MSB]/effective-b[MSB] bits travel with the transaction for flag computation.
- Flow control uses a single global advance: advance = !out_valid || out_ready.
  - in_ready = advance.
  - A transfer occurs on a cycle with in_valid && in_ready.
  - When advance=1, every stage register loads from its predecessor. Stage 0's valid bit loads in_valid.
  - When advance=0, every register holds its value.
- Output handshake: out_valid with sum/cout/ovf stays stable until out_valid && out_ready. Internal bubbles are not squeezed out.
- No combinational path from a/b/cin/sub to any output. in_ready depends combinationally on out_ready and out_valid only.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid = 0, sum = 0, cout = 0, ovf = 0.
  - All internal valid bits and data registers = 0.
  - in_ready = 1 while rst_n is low and after release, since out_valid = 0.
- Latency: a transaction accepted at edge N presents out_valid=1 with its result after edge N+STAGES−1+1, i.e. STAGES cycles later, when there is no stall.
- Throughput: one transaction per cycle while out_ready stays high.
- Stall: out_valid=1 with out_ready=0 freezes the whole pipeline. in_ready=0 in the same cycle, and inputs are ignored.
- Simultaneous pop and push: out_valid && out_ready && in_valid in one cycle accepts the new operand and retires the head in that cycle. No bubble is inserted.
- Reset mid-operation: every in-flight transaction is discarded. After rst_n rises, out_valid stays 0 until a new transaction traverses all STAGES.
- STAGES=1 is legal: a registered full-width adder with 1-cycle latency.
- STAGES=WIDTH is legal: one bit per stage.

## Test plan
All scenarios use WIDTH=16, STAGES=4 unless stated otherwise.
- Reset then idle: out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1.
- Add 0xFFFF + 0x0001, cin=0, sub=0, out_ready=1: exactly 4 cycles later out_valid=1, sum=0x0000, cout=1, ovf=0. This checks carry ripple across all slices.
- Signed overflow in both modes:
  - Add 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1.
  - Sub 0x8000 − 0x0001 → sum=0x7FFF, cout=0, ovf=1.
  - Sub 0x0005 − 0x0007, cin=0 → sum=0xFFFE, cout=1 (borrow), ovf=0.
- Streaming with backpressure:
  - Stimulus: push 8 back-to-back random transactions, holding out_ready low for 3 cycles mid-stream.
  - Required: results match the reference model in order with none lost or duplicated, and sum is stable during the stall. in_ready mirrors advance every cycle.
- Reset mid-operation: assert rst_n low while 3 transactions are in flight, release, then push one add 0x1234 + 0x0F0F, cin=1. Only one out_valid pulse follows, with sum=0x2144.
- Parameter sweep: repeat random add/sub checks at (WIDTH=16, STAGES=1), (8, 8) and (32, 2). Latency must equal STAGES and results must match the reference model.

Source files
------------

// File: rtl/pipelined_adder_sub.sv
// Pipelined ripple-carry adder/subtractor: the carry chain is cut into STAGES registered slices,
// with a global-stall valid/ready handshake on both sides.
module pipelined_adder_sub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SLICE = WIDTH / STAGES;
  localparam int unsigned SW    = SLICE + 1;
  localparam int unsigned LAST  = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  // Per-stage state: valid, carry into this stage's slice, and the flag-side bits
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] sub_q;
  logic [STAGES-1:0] amsb_q;
  logic [STAGES-1:0] bmsb_q;

  // ops_q rotates right one slice per stage: its low slice is the next A slice to add,
  // finished sum slices enter from the top, so after all stages it holds the full sum.
  logic [WIDTH-1:0] ops_q [STAGES];
  // Effective B shifted right one slice per stage; its low slice is always current
  logic [WIDTH-1:0] bop_q [STAGES];

  logic [SLICE:0]   sl   [STAGES];
  logic [WIDTH-1:0] nops [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;

  // Slice adders, one per stage
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sl[k]   = {1'b0, ops_q[k][SLICE-1:0]} + {1'b0, bop_q[k][SLICE-1:0]} + SW'(c_q[k]);
      nops[k] = (ops_q[k] >> SLICE) | (WIDTH'(sl[k][SLICE-1:0]) << (WIDTH - SLICE));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      c_q       <= '0;
      sub_q     <= '0;
      amsb_q    <= '0;
      bmsb_q    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ops_q[k] <= '0;
        bop_q[k] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      // Subtract is a + ~b + ~cin, so the effective carry-in is cin ^ sub
      v_q[0]    <= in_valid;
      ops_q[0]  <= a;
      bop_q[0]  <= b_eff;
      c_q[0]    <= cin ^ sub;
      sub_q[0]  <= sub;
      amsb_q[0] <= a[WIDTH-1];
      bmsb_q[0] <= b_eff[WIDTH-1];
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]    <= v_q[k-1];
        ops_q[k]  <= nops[k-1];
        bop_q[k]  <= bop_q[k-1] >> SLICE;
        c_q[k]    <= sl[k-1][SLICE];
        sub_q[k]  <= sub_q[k-1];
        amsb_q[k] <= amsb_q[k-1];
        bmsb_q[k] <= bmsb_q[k-1];
      end
      out_valid <= v_q[LAST];
      sum       <= nops[LAST];
      cout      <= sl[LAST][SLICE] ^ sub_q[LAST];
      ovf       <= (amsb_q[LAST] == bmsb_q[LAST]) && (nops[LAST][WIDTH-1] != amsb_q[LAST]);
    end
  end

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Scoreboard bench for pipelined_adder_sub: main 16/4 instance plus a parameter sweep.
module tb_pipelined_adder_sub;

  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic [31:0] sw_a, sw_b;
  logic        sw_cin, sw_sub, sw_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sw_pend = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  exp_t nxt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder_sub #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic su);
    logic [16:0] r;
    exp_t e;
    if (su) r = {1'b0, x} - {1'b0, y} - 17'(ci);
    else    r = {1'b0, x} + {1'b0, y} + 17'(ci);
    e.s   = r[15:0];
    e.c   = r[16];
    e.o   = su ? ((x[15] != y[15]) && (r[15] != x[15]))
               : ((x[15] == y[15]) && (r[15] != x[15]));
    e.t   = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Push the expected result whenever a transfer will happen at the next edge
  always @(negedge clk) begin : rec
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      e   = nxt;
      e.t = cyc + 1;
      sb.push_back(e);
    end
  end

  logic        hold_v = 1'b0;
  logic [15:0] hold_s;
  logic        hold_c, hold_o;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready_mirror cyc=%0d got %b want %b", cyc, in_ready, !out_valid || out_ready);
      end
      if (hold_v) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== hold_s || cout !== hold_c || ovf !== hold_o) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got v=%b sum=%h c=%b o=%b want v=1 sum=%h c=%b o=%b",
                   cyc, out_valid, sum, cout, ovf, hold_s, hold_c, hold_o);
        end
      end
      hold_v = out_valid && !out_ready;
      hold_s = sum;
      hold_c = cout;
      hold_o = ovf;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d got sum=%h want no output", cyc, sum);
        end else begin
          e = sb.pop_front();
          if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
            errors++;
            $display("FAIL result cyc=%0d got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                     cyc, sum, cout, ovf, e.s, e.c, e.o);
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.t != STAGES) begin
              errors++;
              $display("FAIL latency got %0d want %0d", cyc - e.t, STAGES);
            end
          end
        end
      end
    end
  end

  // Parameter sweep instances: (16,1), (8,8), (32,2), always ready downstream
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W  = (g == 0) ? 16 : ((g == 1) ? 8 : 32);
    localparam int S  = (g == 0) ? 1  : ((g == 1) ? 8 : 2);
    localparam int W1 = W + 1;
    logic         ir, ov, co, of;
    logic [W-1:0] sm;
    logic [W-1:0] qs[$];
    logic         qc[$];
    logic         qo[$];
    int           qt[$];

    pipelined_adder_sub #(.WIDTH(W), .STAGES(S)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir),
      .a(W'(sw_a)), .b(W'(sw_b)), .cin(sw_cin), .sub(sw_sub),
      .out_valid(ov), .out_ready(1'b1), .sum(sm), .cout(co), .ovf(of)
    );

    always @(negedge clk) begin : srec
      logic [W:0]   r;
      logic [W-1:0] x, y;
      if (rst_n && sw_valid && ir) begin
        x = W'(sw_a);
        y = W'(sw_b);
        if (sw_sub) r = {1'b0, x} - {1'b0, y} - W1'(sw_cin);
        else        r = {1'b0, x} + {1'b0, y} + W1'(sw_cin);
        qs.push_back(r[W-1:0]);
        qc.push_back(r[W]);
        qo.push_back(sw_sub ? ((x[W-1] != y[W-1]) && (r[W-1] != x[W-1]))
                            : ((x[W-1] == y[W-1]) && (r[W-1] != x[W-1])));
        qt.push_back(cyc + 1);
        sw_pend++;
      end
    end

    always @(negedge clk) begin : smon
      logic [W-1:0] es;
      logic         ec, eo;
      int           et;
      if (rst_n && ov) begin
        checks++;
        if (qs.size() == 0) begin
          errors++;
          $display("FAIL sweep%0d_unexpected got sum=%h want no output", g, sm);
        end else begin
          es = qs.pop_front();
          ec = qc.pop_front();
          eo = qo.pop_front();
          et = qt.pop_front();
          sw_pend--;
          if (sm !== es || co !== ec || of !== eo) begin
            errors++;
            $display("FAIL sweep%0d_result got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                     g, sm, co, of, es, ec, eo);
          end
          checks++;
          if (cyc - et != S) begin
            errors++;
            $display("FAIL sweep%0d_latency got %0d want %0d", g, cyc - et, S);
          end
        end
      end
    end
  end

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input logic su, input exp_t e);
    int n;
    @(posedge clk);
    #1;
    a = x; b = y; cin = ci; sub = su; nxt = e; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 want 1");
    end
  endtask

  task automatic directed(input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic su, input logic [15:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s; e.c = c; e.o = o; e.t = 0; e.lat = 1'b1;
    drive(x, y, ci, su, e);
  endtask

  task automatic rnd_drive();
    logic [15:0] x, y;
    logic        ci, su;
    x  = 16'($urandom);
    y  = 16'($urandom);
    ci = 1'($urandom);
    su = 1'($urandom);
    drive(x, y, ci, su, model(x, y, ci, su));
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got %0d pending want 0", nm, sb.size());
    end
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s got v=%b sum=%h c=%b o=%b rdy=%b want v=0 sum=0000 c=0 o=0 rdy=1",
               nm, out_valid, sum, cout, ovf, in_ready);
    end
  endtask

  initial begin
    int n;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_valid = 1'b0;
    nxt = model(16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset_low");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("idle_after_reset");

    // Directed vectors, back to back
    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    directed(16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    directed(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    directed(16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0);
    idle(1);
    drain("directed");

    // Isolated carry ripple across all slices
    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle(6);
    drain("single");

    // Streaming with a 3-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 8; i++) rnd_drive();
        idle(1);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stream");

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) rnd_drive();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    check_idle("reset_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    directed(16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0);
    idle(10);
    drain("after_reset");

    // Parameter sweep
    @(posedge clk);
    #1;
    sw_a = 32'hFFFF_FFFF; sw_b = 32'h0000_0001; sw_cin = 1'b0; sw_sub = 1'b0; sw_valid = 1'b1;
    @(posedge clk);
    #1;
    sw_a = 32'h0000_0005; sw_b = 32'h0000_0007; sw_cin = 1'b1; sw_sub = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom); sw_sub = 1'($urandom);
    end
    @(posedge clk);
    #1 sw_valid = 1'b0;
    n = 0;
    while (sw_pend != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sw_pend != 0) begin
      errors++;
      $display("FAIL sweep_drain got %0d pending want 0", sw_pend);
    end

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_queue got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
